ttl_74161: RTL



---
 rtl/ttl_pkg.sv | 19 +
 rtl/ttl_74161_stage.sv | 40 ++++
 rtl/ttl_74161.sv | 38 +++
 3 files changed

// File: rtl/ttl_pkg.sv
// Shared constants for the TTL counter library.
// TTL_74161_DECADE_EN selects 74160 decade stages instead of binary 74161 stages.
package ttl_pkg;

  localparam int TTL_NIBBLE = 4;

  localparam logic [TTL_NIBBLE-1:0] TTL_TERM_BIN = 4'hF;
  localparam logic [TTL_NIBBLE-1:0] TTL_TERM_DEC = 4'd9;

  // 74160 successor: 9 wraps to 0; the odd illegal codes 11/13/15 fall back to 4.
  function automatic logic [TTL_NIBBLE-1:0] ttl_next_dec(input logic [TTL_NIBBLE-1:0] q);
    logic [TTL_NIBBLE-1:0] nxt;
    nxt = q + 4'd1;
    if (q == TTL_TERM_DEC)  nxt = 4'd0;
    else if (q[0] && q[3])  nxt = 4'd4;
    return nxt;
  endfunction

endpackage

// File: rtl/ttl_74161_stage.sv
// One 4-bit counter chip: 74161 binary by default, 74160 decade when
// TTL_74161_DECADE_EN is defined.
module ttl_74161_stage
  import ttl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  CLR_n,
  input  logic                  LOAD_n,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [TTL_NIBBLE-1:0] D,
  output logic [TTL_NIBBLE-1:0] Q,
  output logic                  RCO
);

  logic [TTL_NIBBLE-1:0] r_q;
  logic [TTL_NIBBLE-1:0] w_next;
  logic                  w_term;

`ifdef TTL_74161_DECADE_EN
  // Decade RCO decodes only QA & QD, so illegal odd codes also raise carry.
  assign w_next = ttl_next_dec(r_q);
  assign w_term = r_q[0] & r_q[3];
`else
  assign w_next = r_q + 4'd1;
  assign w_term = (r_q == TTL_TERM_BIN);
`endif

  // NOTE: sequential state uses non-blocking assignments; the clear is in the
  // sensitivity list so Q drops immediately, without waiting for CLK.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)          r_q <= '0;
    else if (!LOAD_n)    r_q <= D;
    else if (ENP && ENT) r_q <= w_next;
  end

  assign Q   = r_q;
  assign RCO = ENT & w_term;

endmodule

// File: rtl/ttl_74161.sv
// Cascadable synchronous counter built from STAGES 4-bit chips; carry chain is
// combinational so all stages update on the same edge. Decade mode: TTL_74161_DECADE_EN.
module ttl_74161
  import ttl_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic                         CLK,
  input  logic                         CLR_n,
  input  logic                         LOAD_n,
  input  logic                         ENP,
  input  logic                         ENT,
  input  logic [TTL_NIBBLE*STAGES-1:0] D,
  output logic [TTL_NIBBLE*STAGES-1:0] Q,
  output logic                         RCO
);

  // w_ent[k] is the T-enable into stage k; w_ent[k+1] is that stage's RCO.
  logic [STAGES:0] w_ent;

  assign w_ent[0] = ENT;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ttl_74161_stage u_stage (
      .CLK    (CLK),
      .CLR_n  (CLR_n),
      .LOAD_n (LOAD_n),
      .ENP    (ENP),
      .ENT    (w_ent[k]),
      .D      (D[k*TTL_NIBBLE +: TTL_NIBBLE]),
      .Q      (Q[k*TTL_NIBBLE +: TTL_NIBBLE]),
      .RCO    (w_ent[k+1])
    );
  end

  assign RCO = w_ent[STAGES];

endmodule
